// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bundle for nibble_serial_adder
// ports: in_valid/in_ready/A/B/Cin operand side, out_valid/out_ready/Sum/Cout result side
interface nibble_serial_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  modport master (output in_valid, A, B, Cin, out_ready, input in_ready, out_valid, Sum, Cout);
  modport slave  (input in_valid, A, B, Cin, out_ready, output in_ready, out_valid, Sum, Cout);
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit A+B+Cin computed one 4-bit nibble per clock, LSB first
// ports: clk, rst_n (async active-low), bus (slave side: operands in, Sum/Cout out, valid/ready both ways)
module nibble_serial_adder #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic carry_q, cout_q, ov_q;
  logic [IW-1:0] idx_q;
  logic [4:0] nsum;
  logic last;
  assign nsum = {1'b0, a_q[idx_q*4 +: 4]} + {1'b0, b_q[idx_q*4 +: 4]} + 5'(carry_q);
  assign last = idx_q == IW'(NIB - 1);
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = ov_q;
  assign bus.Sum = sum_q;
  assign bus.Cout = cout_q;
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.in_valid) state_nx = ADD;
    if (state == ADD && last) state_nx = DONE;
    if (state == DONE && bus.out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // idx wraps to 0 on the last nibble so the slice select never leaves the operand range
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ov_q <= 1'b0;
      idx_q <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        a_q <= bus.A;
        b_q <= bus.B;
        carry_q <= bus.Cin;
        idx_q <= '0;
      end
      if (state == ADD) begin
        sum_q[idx_q*4 +: 4] <= nsum[3:0];
        carry_q <= nsum[4];
        idx_q <= last ? '0 : idx_q + 1'b1;
        if (last) begin
          cout_q <= nsum[4];
          ov_q <= 1'b1;
        end
      end
      if (state == DONE && bus.out_ready) ov_q <= 1'b0;
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and scoreboarded checks of nibble_serial_adder at WIDTH 16, 4 and 32
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  nibble_serial_adder_if #(.WIDTH(16)) bus16();
  nibble_serial_adder_if #(.WIDTH(4)) bus4();
  nibble_serial_adder_if #(.WIDTH(32)) bus32();
  nibble_serial_adder #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus16));
  nibble_serial_adder #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  nibble_serial_adder #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] es, input logic ec);
    int n;
    bus16.A = a;
    bus16.B = b;
    bus16.Cin = cin;
    bus16.in_valid = 1'b1;
    tick;
    bus16.in_valid = 1'b0;
    n = 0;
    while (!bus16.out_valid && n < 20) begin
      tick;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd4);
    check({tag, " sum"}, 64'(bus16.Sum), 64'(es));
    check({tag, " cout"}, 64'(bus16.Cout), 64'(ec));
  endtask
  task automatic release16(input string tag);
    bus16.out_ready = 1'b1;
    tick;
    bus16.out_ready = 1'b0;
    check({tag, " in_ready after release"}, 64'(bus16.in_ready), 64'd1);
    check({tag, " out_valid after release"}, 64'(bus16.out_valid), 64'd0);
  endtask
  initial begin
    logic [16:0] q[$];
    logic [16:0] seen;
    logic acc, fire, stray;
    int got, cyc, l4, l32, n;
    {bus16.in_valid, bus16.out_ready, bus16.A, bus16.B, bus16.Cin} = '0;
    {bus4.in_valid, bus4.out_ready, bus4.A, bus4.B, bus4.Cin} = '0;
    {bus32.in_valid, bus32.out_ready, bus32.A, bus32.B, bus32.Cin} = '0;
    #12;
    check("reset sum", 64'(bus16.Sum), 64'd0);
    check("reset cout", 64'(bus16.Cout), 64'd0);
    check("reset out_valid", 64'(bus16.out_valid), 64'd0);
    rst_n = 1'b1;
    tick;
    check("in_ready after reset", 64'(bus16.in_ready), 64'd1);
    run16("T1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    release16("T1");
    run16("T2a", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    release16("T2a");
    run16("T2b", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    bus16.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("T3 held sum", 64'(bus16.Sum), 64'hFFFF);
      check("T3 held cout", 64'(bus16.Cout), 64'd1);
      check("T3 held out_valid", 64'(bus16.out_valid), 64'd1);
      check("T3 in_ready low", 64'(bus16.in_ready), 64'd0);
    end
    bus16.in_valid = 1'b0;
    release16("T3");
    run16("T3b", 16'h8001, 16'h7FFF, 1'b0, 16'h0000, 1'b1);
    release16("T3b");
    bus16.A = 16'hABCD;
    bus16.B = 16'h1111;
    bus16.Cin = 1'b1;
    bus16.in_valid = 1'b1;
    tick;
    bus16.in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("T4 reset sum", 64'(bus16.Sum), 64'd0);
    check("T4 reset cout", 64'(bus16.Cout), 64'd0);
    check("T4 reset out_valid", 64'(bus16.out_valid), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    check("T4 in_ready after release", 64'(bus16.in_ready), 64'd1);
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      stray |= bus16.out_valid;
    end
    check("T4 no stale result", 64'(stray), 64'd0);
    got = 0;
    cyc = 0;
    bus16.A = 16'($urandom);
    bus16.B = 16'($urandom);
    bus16.Cin = 1'($urandom);
    bus16.in_valid = 1'b1;
    bus16.out_ready = 1'($urandom);
    while (got < 1000 && cyc < 30000) begin
      acc = bus16.in_valid && bus16.in_ready;
      fire = bus16.out_valid && bus16.out_ready;
      seen = {bus16.Cout, bus16.Sum};
      tick;
      cyc++;
      if (acc) begin
        q.push_back({1'b0, bus16.A} + {1'b0, bus16.B} + 17'(bus16.Cin));
        bus16.A = 16'($urandom);
        bus16.B = 16'($urandom);
        bus16.Cin = 1'($urandom);
      end
      if (fire) begin
        if (q.size() == 0) check("T5 extra result", 64'(seen), 64'h1FFFF + 64'd1);
        else check("T5 result", 64'(seen), 64'(q.pop_front()));
        got++;
      end
      bus16.out_ready = 1'($urandom);
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b0;
    check("T5 results received", 64'(got), 64'd1000);
    check("T5 results pending", 64'(q.size()), 64'd0);
    tick;
    tick;
    bus4.A = 4'hF;
    bus4.B = 4'h1;
    bus32.A = 32'hFFFF_FFFF;
    bus32.B = 32'h1;
    bus4.in_valid = 1'b1;
    bus32.in_valid = 1'b1;
    tick;
    bus4.in_valid = 1'b0;
    bus32.in_valid = 1'b0;
    l4 = -1;
    l32 = -1;
    n = 0;
    while ((l4 < 0 || l32 < 0) && n < 20) begin
      tick;
      n++;
      if (bus4.out_valid && l4 < 0) l4 = n;
      if (bus32.out_valid && l32 < 0) l32 = n;
    end
    check("T6 w4 latency", 64'(l4), 64'd1);
    check("T6 w32 latency", 64'(l32), 64'd8);
    check("T6 w4 sum", 64'(bus4.Sum), 64'd0);
    check("T6 w4 cout", 64'(bus4.Cout), 64'd1);
    check("T6 w32 sum", 64'(bus32.Sum), 64'd0);
    check("T6 w32 cout", 64'(bus32.Cout), 64'd1);
    bus4.out_ready = 1'b1;
    bus32.out_ready = 1'b1;
    tick;
    check("T6 w4 in_ready after release", 64'(bus4.in_ready), 64'd1);
    check("T6 w32 in_ready after release", 64'(bus32.in_ready), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
